ball_sequencer: RTL
===================

Name: ball_sequencer

Overview:
Sequences the 8-LED ball datapath for the 2-player Pong game.
- Holds the one-hot ball position.
- Steps the ball at a level-dependent rate.
- Judges paddle presses as hit, early swing or miss.
- Escalates speed level every N hits.

Sits beneath the game controller, which issues serves and consumes the miss/hit pulses for scoring.

Parameters:
TICK_BASE, 20, clocks per ball step at level 0
TICK_DEC, 4, clocks removed from step period per level
LVL_MAX, 3, highest speed level (saturating); TICK_BASE > LVL_MAX*TICK_DEC required
HITS_PER_LVL, 4, consecutive hits needed to raise level

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  synchronous active-high reset
Serve  in  1  single-cycle serve request from game controller
ServeSide  in  1  0 = P1 serves (ball starts at Led[7]), 1 = P2 serves (starts at Led[0])
P1_btn  in  1  P1 paddle button, level, already synchronized; P1 owns Led[7]
P2_btn  in  1  P2 paddle button, level, already synchronized; P2 owns Led[0]
Led  out  8  one-hot ball position, 0 when idle
Hit  out  1  one-cycle pulse on a valid return
Miss_p1  out  1  one-cycle pulse, P1 lost the rally
Miss_p2  out  1  one-cycle pulse, P2 lost the rally
Level  out  2  current speed level 0..LVL_MAX
Busy  out  1  high while a rally is in progress

Behaviour:
- Reset (sync, Rst=1 at edge), including mid-rally:
  - State=IDLE; Led=0, Hit=0, Miss_p1=0, Miss_p2=0, Level=0, Busy=0.
  - Tick counter=0, hit counter=0.
  - Button-history regs=1, so a button held through reset is not an edge.
- Edge detect: press = btn & ~btn_q; btn_q is registered every cycle.
- States: IDLE, TO_P2 (Led shifts right), TO_P1 (Led shifts left).
- Step period P = TICK_BASE − Level*TICK_DEC.
  - Tick counter runs 0..P−1 in TO_P1/TO_P2; a step fires on the cycle it equals P−1, then the counter wraps to 0.
  - The counter is cleared on serve and on hit.
- IDLE:
  - Serve=1 with ServeSide=0: next edge Led=8'h80, state TO_P2.
  - Serve=1 with ServeSide=1: next edge Led=8'h01, state TO_P1.
  - Serve also clears Level and the hit counter. Busy=1 from that edge.
  - Button presses are ignored.
- Serve while Busy=1 is ignored.
- TO_P2, evaluated each cycle in this priority:
  1. P2 press with Led==8'h01: Hit=1 next cycle, state TO_P1, Led unchanged, tick counter cleared, hit counter+1.
  2. P2 press with Led!=8'h01 (early swing): Miss_p2=1, Led=0, IDLE.
  3. Step with Led==8'h01 (no press in window): Miss_p2=1, Led=0, IDLE.
  4. Step otherwise: Led <= Led>>1.
  - P1 presses are ignored.
- TO_P1: mirror of TO_P2 with P1_btn, Led==8'h80, Led<<1, Miss_p1.
- A hit that coincides with a step is a hit; the step is discarded.
- Level escalation:
  - When a hit makes the hit counter equal HITS_PER_LVL, the counter resets to 0 and Level increments, saturating at LVL_MAX.
  - The new period applies from the next count.
- Miss pulse and Led=0 land on the same edge; Busy falls on that edge too.
- Hit/Miss pulses last exactly one cycle.
- Latency:
  - Serve to first Led: 1 clock.
  - Serve to first step: P clocks after Led appears.
  - Press to Hit/Miss: 1 clock.
- Ball dwell: the ball dwells P clocks on each LED, including the end LED (hit window = P clocks).

Test Plan:
Run with TICK_BASE=8, TICK_DEC=2, LVL_MAX=3, HITS_PER_LVL=2.
1. Reset with P1_btn held high, release Rst, Serve, ServeSide=0:
   - Led=8'h80 one clock after Serve; Led=8'h40 exactly 8 clocks later.
   - No Hit/Miss from the held button.
2. Let ball reach 8'h01 with no press:
   - Miss_p2 pulses once, 8 clocks after Led becomes 8'h01.
   - Led=0, Busy=0 on the same edge.
3. P2 press while Led=8'h01, on the same cycle as the step:
   - Hit=1 next clock; Led stays 8'h01; next shift to 8'h02 exactly 8 clocks after the hit.
4. P2 press while Led=8'h04 moving toward P2:
   - Miss_p2 next clock; Led=0.
   - Simultaneous P1 press the same cycle is ignored.
5. Four consecutive valid hits:
   - Level 0→1 after hit 2, 1→2 after hit 4.
   - Step period measured 8→6→4 clocks.
   - A new Serve returns Level to 0.
6. Rst asserted mid-rally at Led=8'h10:
   - All outputs 0 next edge.
   - Serve during a rally is ignored: Led sequence unaffected.

Source files
------------

// File: rtl/ball_sequencer.sv
// -----------------------------------------------------------------------------
// ball_sequencer
// Ball datapath for the 8-LED, 2-player Pong game. Holds the one-hot ball
// position, steps it at a level-dependent rate and judges paddle presses as
// hits, early swings or misses. The speed level rises every HITS_PER_LVL
// consecutive returns.
//
// Ports:
//   Clk        system clock, rising edge
//   Rst        synchronous active-high reset
//   Serve      single-cycle serve request (ignored while a rally is running)
//   ServeSide  0: P1 serves from Led[7], 1: P2 serves from Led[0]
//   P1_btn     P1 paddle level (synchronized), P1 owns Led[7]
//   P2_btn     P2 paddle level (synchronized), P2 owns Led[0]
//   Led        one-hot ball position, 0 when idle
//   Hit        one-cycle pulse on a valid return
//   Miss_p1    one-cycle pulse, P1 lost the rally
//   Miss_p2    one-cycle pulse, P2 lost the rally
//   Level      current speed level 0..LVL_MAX
//   Busy       high while a rally is in progress
// -----------------------------------------------------------------------------
module ball_sequencer #(
  parameter int TICK_BASE    = 20,
  parameter int TICK_DEC     = 4,
  parameter int LVL_MAX      = 3,
  parameter int HITS_PER_LVL = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Serve,
  input  logic       ServeSide,
  input  logic       P1_btn,
  input  logic       P2_btn,
  output logic [7:0] Led,
  output logic       Hit,
  output logic       Miss_p1,
  output logic       Miss_p2,
  output logic [1:0] Level,
  output logic       Busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TO_P2 = 2'd1,  // ball moving right, towards Led[0]
    TO_P1 = 2'd2   // ball moving left, towards Led[7]
  } state_t;

  localparam int TW = (TICK_BASE > 1) ? $clog2(TICK_BASE) : 1;
  localparam int HW = (HITS_PER_LVL > 1) ? $clog2(HITS_PER_LVL + 1) : 1;

  state_t          state_q, state_d;
  logic [7:0]      led_q, led_d;
  logic            hit_q, hit_d;
  logic            miss1_q, miss1_d;
  logic            miss2_q, miss2_d;
  logic [1:0]      level_q, level_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [HW-1:0]   hits_q, hits_d;
  logic            p1_q, p2_q;

  logic            p1_press, p2_press;
  logic [TW-1:0]   period_m1;
  logic            step;
  logic            to_p2;
  logic            press_now;
  logic            at_end;

  // State / datapath register.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      led_q   <= '0;
      hit_q   <= 1'b0;
      miss1_q <= 1'b0;
      miss2_q <= 1'b0;
      level_q <= '0;
      tick_q  <= '0;
      hits_q  <= '0;
      // History starts high so a button held through reset is not an edge.
      p1_q    <= 1'b1;
      p2_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      hit_q   <= hit_d;
      miss1_q <= miss1_d;
      miss2_q <= miss2_d;
      level_q <= level_d;
      tick_q  <= tick_d;
      hits_q  <= hits_d;
      p1_q    <= P1_btn;
      p2_q    <= P2_btn;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d   = state_q;
    led_d     = led_q;
    hit_d     = 1'b0;
    miss1_d   = 1'b0;
    miss2_d   = 1'b0;
    level_d   = level_q;
    tick_d    = tick_q;
    hits_d    = hits_q;

    p1_press  = P1_btn & ~p1_q;
    p2_press  = P2_btn & ~p2_q;
    period_m1 = TW'(TICK_BASE - 1 - int'(level_q) * TICK_DEC);
    step      = (tick_q == period_m1);

    // Both rally directions share one judge: only the receiving player's
    // button counts, and the receiver's end LED is the hit window.
    to_p2     = (state_q == TO_P2);
    press_now = to_p2 ? p2_press : p1_press;
    at_end    = (led_q == (to_p2 ? 8'h01 : 8'h80));

    unique case (state_q)
      IDLE: begin
        if (Serve) begin
          state_d = ServeSide ? TO_P1 : TO_P2;
          led_d   = ServeSide ? 8'h01 : 8'h80;
          tick_d  = '0;
          hits_d  = '0;
          level_d = '0;
        end
      end

      TO_P2, TO_P1: begin
        tick_d = step ? '0 : tick_q + TW'(1);
        if (press_now && at_end) begin
          // Valid return; a step on the same cycle is discarded.
          hit_d   = 1'b1;
          state_d = to_p2 ? TO_P1 : TO_P2;
          tick_d  = '0;
          if (hits_q == HW'(HITS_PER_LVL - 1)) begin
            hits_d = '0;
            if (level_q != 2'(LVL_MAX)) level_d = level_q + 2'd1;
          end else begin
            hits_d = hits_q + HW'(1);
          end
        end else if (press_now || (step && at_end)) begin
          // Early swing, or the ball left the end LED unreturned.
          state_d = IDLE;
          led_d   = '0;
          tick_d  = '0;
          miss1_d = ~to_p2;
          miss2_d = to_p2;
        end else if (step) begin
          led_d = to_p2 ? (led_q >> 1) : (led_q << 1);
        end
      end

      default: begin
        state_d = IDLE;
        led_d   = '0;
        tick_d  = '0;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    Led     = led_q;
    Hit     = hit_q;
    Miss_p1 = miss1_q;
    Miss_p2 = miss2_q;
    Level   = level_q;
    Busy    = (state_q != IDLE);
  end

endmodule
